seq_divider: RTL and testbench

- Multi-cycle restoring integer divider for the CPU datapath.
- Does the inverse of the adder chain: one shift-and-subtract step per cycle.
- Accepts dividend and divisor on a start pulse and returns quotient and remainder WIDTH+1 cycles later.
- Gives the core a DIV/DIVU execution unit with a start/done handshake.

---
 rtl/seq_divider_if.sv | 41 ++++
 rtl/seq_divider.sv | 206 ++++++++++++++++++++
 tb/tb_seq_divider.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/response bundle for the sequential divider.
//
// The master (the requesting core) drives the operands and the start pulse.
// The slave (the divider) returns the status, the results and the
// divide-by-zero flag.
//
// Signals:
//   start        request pulse, sampled by the divider only while busy=0
//   dividend     numerator, captured when start is accepted
//   divisor      denominator, captured when start is accepted
//   sign_op      1 = signed division (honoured only when DIV_SIGNED_EN is defined)
//   busy         high while an operation is in flight (CALC or FIN)
//   done         one-cycle pulse; the results are valid in this cycle
//   quotient     registered result
//   remainder    registered result
//   div_by_zero  set together with done when the captured divisor was 0
interface seq_divider_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             sign_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, sign_op,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, sign_op,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider (DIV/DIVU unit).
//
// One shift-and-subtract step is performed per clock. Operands are captured
// on an accepted start. The quotient and remainder are registered on the
// edge that enters FIN, so done rises WIDTH+1 cycles after the start cycle,
// or 1 cycle after it when the divisor is zero.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   div_if  seq_divider_if.slave (start/operands in; busy/done/results out)
//
// Parameters:
//   WIDTH   operand, quotient and remainder width in bits (>= 2)
//
// Build option:
//   DIV_SIGNED_EN  when defined, sign_op=1 selects signed division. The
//                  operand magnitudes go through the unsigned core, and the
//                  results are sign-corrected on entry to FIN. When the
//                  macro is undefined, sign_op is ignored and no sign logic
//                  is built.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; results from the previous operation are held
// CALC  | one restoring step per cycle; the counter runs from WIDTH to 0
// FIN   | results valid, done=1 for this single cycle
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave div_if
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0] wq_q, wq_d;       // working quotient (initially the dividend)
  logic [WIDTH-1:0] dvs_q, dvs_d;     // captured divisor magnitude
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Datapath for one restoring step
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_prem;
  logic [WIDTH-1:0] step_wq;

  // Operand preparation at acceptance, and the final result formatting
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic dvd_neg;
  logic dvs_neg;
`else
  logic unused_sign_op;
`endif

  // {prem, wq} behaves as one register shifted left by 1. The trial
  // subtraction is WIDTH+1 bits wide, so its MSB is the borrow: 1 means
  // the shifted remainder is smaller than the divisor, and the step restores.
  always_comb begin
    shifted   = {prem_q, wq_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};
    step_prem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    step_wq   = {wq_q[WIDTH-2:0], ~trial[WIDTH]};
  end

`ifdef DIV_SIGNED_EN
  // The most-negative dividend negates to itself. Read as unsigned, that is
  // the correct magnitude, so MIN / -1 yields MIN with no special case.
  always_comb begin
    dvd_neg = div_if.sign_op & div_if.dividend[WIDTH-1];
    dvs_neg = div_if.sign_op & div_if.divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~div_if.dividend + 1'b1) : div_if.dividend;
    dvs_mag = dvs_neg ? (~div_if.divisor + 1'b1) : div_if.divisor;
    fin_quo = neg_quo_q ? (~step_wq + 1'b1) : step_wq;
    fin_rem = neg_rem_q ? (~step_prem + 1'b1) : step_prem;
  end
`else
  always_comb begin
    dvd_mag = div_if.dividend;
    dvs_mag = div_if.divisor;
    fin_quo = step_wq;
    fin_rem = step_prem;
  end

  assign unused_sign_op = div_if.sign_op;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    wq_d    = wq_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (div_if.start) begin
          prem_d = '0;
          wq_d   = dvd_mag;
          dvs_d  = dvs_mag;
          cnt_d  = CW'(WIDTH);
`ifdef DIV_SIGNED_EN
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
`endif
          if (div_if.divisor == '0) begin
            // The divide-by-zero result is known at once, so skip CALC.
            // The remainder is the original dividend, not its magnitude.
            state_d = FIN;
            quo_d   = '1;
            rem_d   = div_if.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        prem_d = step_prem;
        wq_d   = step_wq;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
          quo_d   = fin_quo;
          rem_d   = fin_rem;
          dbz_d   = 1'b0;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      wq_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      wq_q    <= wq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  assign div_if.busy        = (state_q != IDLE);
  assign div_if.done        = (state_q == FIN);
  assign div_if.quotient    = quo_q;
  assign div_if.remainder   = rem_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {quotient, remainder}.
  function automatic logic [2*W-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
`ifdef DIV_SIGNED_EN
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
      end
`else
      sa = 0;
      sb = longint'(s);
`endif
    end
    return {q, r};
  endfunction

  // Timing model: m_cnt = number of busy cycles still to come, including
  // the current one; done is expected in the last of them.
  int           m_cnt;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_z;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_q   <= '0;
      m_r   <= '0;
      m_z   <= 1'b0;
      p_q   <= '0;
      p_r   <= '0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_q <= p_q;
        m_r <= p_r;
        m_z <= 1'b0;
      end
    end else if (dif.start) begin
      if (dif.divisor == '0) begin
        m_cnt <= 1;
        m_q   <= '1;
        m_r   <= dif.dividend;
        m_z   <= 1'b1;
      end else begin
        m_cnt <= W + 1;
        {p_q, p_r} <= model_div(dif.dividend, dif.divisor, dif.sign_op);
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 64'(dif.busy), 64'(m_cnt > 0));
    check("cyc_done", 64'(dif.done), 64'(m_cnt == 1));
    check("cyc_quotient", 64'(dif.quotient), 64'(m_q));
    check("cyc_remainder", 64'(dif.remainder), 64'(m_r));
    check("cyc_dbz", 64'(dif.div_by_zero), 64'(m_z));
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    dif.dividend = a;
    dif.divisor  = b;
    dif.sign_op  = s;
    dif.start    = 1'b1;
  endtask

  // Counts cycles after the start cycle until done; n is the done cycle.
  task automatic wait_done(output int n, output logic b1);
    n  = 0;
    b1 = 1'b0;
    do begin
      @(negedge clk);
      dif.start = 1'b0;
      n++;
      if (n == 1) b1 = dif.busy;
    end while (!dif.done && n < 100);
    if (!dif.done) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int lat, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ez);
    int   n;
    logic b1;
    issue(a, b, s);
    wait_done(n, b1);
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_busy_c1"}, 64'(b1), 64'(1));
    check({name, "_q"}, 64'(dif.quotient), 64'(eq));
    check({name, "_r"}, 64'(dif.remainder), 64'(er));
    check({name, "_dbz"}, 64'(dif.div_by_zero), 64'(ez));
  endtask

  initial begin
    int   n;
    int   ndone;
    logic b1;
    logic [W-1:0] sq, sr;

    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    dif.sign_op  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(dif.busy), 64'(0));
    check("reset_done", 64'(dif.done), 64'(0));
    check("reset_q", 64'(dif.quotient), 64'(0));
    check("reset_r", 64'(dif.remainder), 64'(0));
    check("reset_dbz", 64'(dif.div_by_zero), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic: 100 / 7
    run_op("div100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    check("idle_after_fin_busy", 64'(dif.busy), 64'(0));

    // Divide by zero, then a normal operation clears the flag
    run_op("div5_0", 32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("div9_3", 32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0, 1'b0);

    // Start while busy is ignored
    issue(32'hFFFF_FFFF, 32'h10, 1'b0);
    ndone = 0;
    sq    = '0;
    sr    = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      dif.start = 1'b0;
      if (c == 10) begin
        dif.dividend = 32'd8;
        dif.divisor  = 32'd2;
        dif.start    = 1'b1;
      end
      if (dif.done) begin
        ndone++;
        sq = dif.quotient;
        sr = dif.remainder;
        check("ignored_start_done_cycle", 64'(c), 64'(33));
      end
    end
    check("ignored_start_ndone", 64'(ndone), 64'(1));
    check("ignored_start_q", 64'(sq), 64'(32'h0FFF_FFFF));
    check("ignored_start_r", 64'(sr), 64'(32'hF));

    // Reset mid-operation
    issue(32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(dif.busy), 64'(0));
    check("abort_done", 64'(dif.done), 64'(0));
    check("abort_q", 64'(dif.quotient), 64'(0));
    check("abort_r", 64'(dif.remainder), 64'(0));
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'(0));
    run_op("div1000_3", 32'd1000, 32'd3, 1'b0, 33, 32'd333, 32'd1, 1'b0);

    // Boundaries
    run_op("div5_9", 32'd5, 32'd9, 1'b0, 33, 32'd0, 32'd5, 1'b0);
    run_op("div0_5", 32'd0, 32'd5, 1'b0, 33, 32'd0, 32'd0, 1'b0);
    run_op("divmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Back-to-back: start held across FIN is accepted in the following IDLE cycle
    issue(32'd7, 32'd7, 1'b0);
    wait_done(n, b1);
    check("b2b_first_q", 64'(dif.quotient), 64'(1));
    dif.dividend = 32'd200;
    dif.divisor  = 32'd9;
    dif.start    = 1'b1;
    @(negedge clk);
    check("b2b_idle_busy", 64'(dif.busy), 64'(0));
    wait_done(n, b1);
    check("b2b_latency", 64'(n), 64'(33));
    check("b2b_q", 64'(dif.quotient), 64'(22));
    check("b2b_r", 64'(dif.remainder), 64'(2));

`ifdef DIV_SIGNED_EN
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0, 1'b0);
    run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("sdiv_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`else
    run_op("udiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    // Pin the reference model itself against hand-computed values
    check("model_100_7", 64'(model_div(32'd100, 32'd7, 1'b0)), {32'd14, 32'd2});
    check("model_div0", 64'(model_div(32'd5, 32'd0, 1'b0)), {32'hFFFF_FFFF, 32'd5});

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
